alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters in the multi-cycle CPU: requester 0 is PC/branch-target update, requester 1 is the execute stage.
- Accepts valid/ready operation requests and grants at most one per cycle, round-robin.
- Drives the ALU operands, func_code and branch_type for the granted requester.
- Registers C/overflow_flag/bcond into a per-requester response slot that is held until consumed.

Parameters:
- NUM_BITS, 16, datapath width of operands and result.
- RESET_PRIO, 0, requester holding priority immediately after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rq_valid  in  2  per-requester request valid (bit i = requester i).
- rq_ready  out  2  per-requester request accepted this cycle (combinational grant).
- rq_a  in  2*NUM_BITS  operand A, requester i in bits [i*NUM_BITS +: NUM_BITS].
- rq_b  in  2*NUM_BITS  operand B, same packing.
- rq_func  in  8  func_code, 4 bits per requester.
- rq_btype  in  4  branch_type, 2 bits per requester.
- rs_valid  out  2  per-requester response valid.
- rs_ready  in  2  per-requester response consumed.
- rs_c  out  2*NUM_BITS  registered ALU result per requester.
- rs_ovf  out  2  registered overflow_flag per requester.
- rs_bcond  out  2  registered bcond per requester.
- alu_a, alu_b  out  NUM_BITS each  ALU operands.
- alu_func  out  4  ALU func_code.
- alu_btype  out  2  ALU branch_type.
- alu_c  in  NUM_BITS  ALU result.
- alu_ovf  in  1  ALU overflow_flag.
- alu_bcond  in  1  ALU bcond.

Behaviour:
- Single clock domain. All state changes on the rising edge of clk. reset is synchronous and active-high.
- Reset values:
  - rs_valid = 0, rs_c = 0, rs_ovf = 0, rs_bcond = 0.
  - Priority pointer = RESET_PRIO.
- Per-requester slot has two states:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY when rs_ready=1 while rs_valid=1.
  - FULL -> FULL (reloaded) when a release and a new grant to the same requester occur in the same cycle.
- Eligibility: requester i is eligible when rq_valid[i]=1 and (slot i EMPTY, or slot i FULL with rs_ready[i]=1 this cycle). This gives back-to-back throughput of one operation per cycle per requester.
- Grant, combinational:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester named by the pointer.
  - rq_ready = one-hot grant, or 0 when no grant.
- Pointer update: after any grant, the pointer moves to the non-granted requester. With no grant it holds.
- ALU drive:
  - Granted: alu_* = the granted requester's operands, func_code and branch_type.
  - No grant: alu_a=0, alu_b=0, alu_func=FUNC_ID1, alu_btype=0.
- Capture, on the grant edge, into the granted slot:
  - rs_c <= alu_c.
  - rs_ovf <= alu_ovf.
  - rs_bcond <= (alu_func==FUNC_Bxx) ? alu_bcond : 0. The ALU holds bcond across non-branch ops, so it must be masked.
- Latency: grant in cycle N, rs_valid=1 from cycle N+1.
- Hold: rs_c, rs_ovf and rs_bcond stay stable while rs_valid=1 and rs_ready=0. Requests arriving in that time get rq_ready=0.
- Requester sources: requesters keep rq_* stable until rq_ready. The arbiter does not latch request operands.
- Simultaneous events per cycle: release of either slot, a grant, and the pointer update all happen on the same edge, without interaction.
- Reset mid-operation: pending responses are dropped (rs_valid=0 next cycle) and no grant is made in the reset cycle (rq_ready=0 while reset=1).

Decomposition:
- Shared package/header: FUNC_* codes (from opcodes.v), branch-type constants BNE=0, BEQ=1, BGZ=2, BLZ=3, NUM_BITS default.
- One natural sub-module: alu_rsp_slot. It holds one requester's response register and its EMPTY/FULL state, with inputs load/release/data and outputs valid/c/ovf/bcond. Instantiate it twice.

Test Plan:
- Reset, then r1 requests ADD 0x0003+0x0004, rs_ready[1]=1 -> rq_ready=2'b10 same cycle; next cycle rs_valid[1]=1, rs_c=0x0007, rs_ovf=0.
- Both request every cycle with RESET_PRIO=0, rs_ready=2'b11 -> grants alternate 01,10,01,10; each rs_valid follows its grant by exactly one cycle.
- r0 does ADD 0x7FFF+0x0001 with rs_ready[0]=0 for 3 cycles -> rs_c=0x8000 and rs_ovf=1 held stable; rq_ready[0]=0 for a new r0 request until the release cycle, then granted in that same cycle.
- r1 does Bxx BGZ A=0x0005, then SUB 0x0005-0x0005 -> first rs_bcond=1, second rs_c=0x0000 with rs_bcond=0 (masked).
- Only r1 active, then both active -> pointer after the r1 grant is 0, so r0 wins the tie.
- reset=1 while both slots are FULL and both rq_valid=1 -> next cycle rs_valid=0, rq_ready=0 during reset, pointer=RESET_PRIO.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU sharing arbiter: ALU func codes, branch types
// and the response-slot state encoding.
package alu_share_arbiter_pkg;

  localparam int unsigned NUM_BITS_DEF = 16;

  // ALU func_code values, matching the CPU opcode definitions
  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_ID1  = 4'd2;
  localparam logic [3:0] FUNC_NOT  = 4'd3;
  localparam logic [3:0] FUNC_AND  = 4'd4;
  localparam logic [3:0] FUNC_ORR  = 4'd5;
  localparam logic [3:0] FUNC_NAND = 4'd6;
  localparam logic [3:0] FUNC_NOR  = 4'd7;
  localparam logic [3:0] FUNC_XOR  = 4'd8;
  localparam logic [3:0] FUNC_XNOR = 4'd9;
  localparam logic [3:0] FUNC_LLS  = 4'd10;
  localparam logic [3:0] FUNC_LRS  = 4'd11;
  localparam logic [3:0] FUNC_ALS  = 4'd12;
  localparam logic [3:0] FUNC_ARS  = 4'd13;
  localparam logic [3:0] FUNC_TCP  = 4'd14;
  localparam logic [3:0] FUNC_BXX  = 4'd15;

  // ALU branch_type values
  localparam logic [1:0] BNE = 2'd0;
  localparam logic [1:0] BEQ = 2'd1;
  localparam logic [1:0] BGZ = 2'd2;
  localparam logic [1:0] BLZ = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // The ALU holds bcond across non-branch ops, so only branch ops report it.
  function automatic logic mask_bcond(input logic [3:0] func, input logic bcond);
    return (func == FUNC_BXX) ? bcond : 1'b0;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rsp_slot.sv
// One requester's response slot: a registered ALU result held until consumed.
module alu_rsp_slot
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                release_en,
  input  logic [NUM_BITS-1:0] data_c,
  input  logic                data_ovf,
  input  logic                data_bcond,
  output logic                valid,
  output logic [NUM_BITS-1:0] c,
  output logic                ovf,
  output logic                bcond
);

  slot_state_e         state_q, state_d;
  logic [NUM_BITS-1:0] c_q, c_d;
  logic                ovf_q, ovf_d;
  logic                bcond_q, bcond_d;

  // Next state: a load wins over a same-cycle release (reload), else release empties
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    bcond_d = bcond_q;
    if (load) begin
      state_d = SLOT_FULL;
      c_d     = data_c;
      ovf_d   = data_ovf;
      bcond_d = data_bcond;
    end else if (release_en && (state_q == SLOT_FULL)) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot state and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      bcond_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      bcond_q <= bcond_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign c     = c_q;
  assign ovf   = ovf_q;
  assign bcond = bcond_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of the single ALU between PC update (requester 0) and
// execute (requester 1), with a held response slot per requester.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BITS   = NUM_BITS_DEF,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [2*NUM_BITS-1:0] rq_a,
  input  logic [2*NUM_BITS-1:0] rq_b,
  input  logic [7:0]            rq_func,
  input  logic [3:0]            rq_btype,
  output logic [1:0]            rs_valid,
  input  logic [1:0]            rs_ready,
  output logic [2*NUM_BITS-1:0] rs_c,
  output logic [1:0]            rs_ovf,
  output logic [1:0]            rs_bcond,
  output logic [NUM_BITS-1:0]   alu_a,
  output logic [NUM_BITS-1:0]   alu_b,
  output logic [3:0]            alu_func,
  output logic [1:0]            alu_btype,
  input  logic [NUM_BITS-1:0]   alu_c,
  input  logic                  alu_ovf,
  input  logic                  alu_bcond
);

  logic [1:0] elig;
  logic [1:0] gnt;
  logic       prio_q, prio_d;
  logic       bcond_cap;

  // Eligibility and one-hot round-robin grant; nothing is granted during reset
  always_comb begin
    elig = '0;
    gnt  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      elig[i] = ~reset & rq_valid[i] & (~rs_valid[i] | rs_ready[i]);
    end
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  assign rq_ready = gnt;

  // ALU operand mux; idle ALU sees an identity op on zero operands
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = FUNC_ID1;
    alu_btype = '0;
    if (gnt[0]) begin
      alu_a     = rq_a[0 +: NUM_BITS];
      alu_b     = rq_b[0 +: NUM_BITS];
      alu_func  = rq_func[3:0];
      alu_btype = rq_btype[1:0];
    end else if (gnt[1]) begin
      alu_a     = rq_a[NUM_BITS +: NUM_BITS];
      alu_b     = rq_b[NUM_BITS +: NUM_BITS];
      alu_func  = rq_func[7:4];
      alu_btype = rq_btype[3:2];
    end
  end

  // Priority moves to the requester that was not granted; holds when idle
  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= (RESET_PRIO != 0);
    end else begin
      prio_q <= prio_d;
    end
  end

  assign bcond_cap = mask_bcond(alu_func, alu_bcond);

  alu_rsp_slot #(.NUM_BITS(NUM_BITS)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .load       (gnt[0]),
    .release_en (rs_ready[0]),
    .data_c     (alu_c),
    .data_ovf   (alu_ovf),
    .data_bcond (bcond_cap),
    .valid      (rs_valid[0]),
    .c          (rs_c[0 +: NUM_BITS]),
    .ovf        (rs_ovf[0]),
    .bcond      (rs_bcond[0])
  );

  alu_rsp_slot #(.NUM_BITS(NUM_BITS)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .load       (gnt[1]),
    .release_en (rs_ready[1]),
    .data_c     (alu_c),
    .data_ovf   (alu_ovf),
    .data_bcond (bcond_cap),
    .valid      (rs_valid[1]),
    .c          (rs_c[NUM_BITS +: NUM_BITS]),
    .ovf        (rs_ovf[1]),
    .bcond      (rs_bcond[1])
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU plus a slot/priority reference model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int unsigned NB = 16;
  localparam int          RP = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rq_valid, rq_ready;
  logic [2*NB-1:0] rq_a, rq_b;
  logic [7:0]    rq_func;
  logic [3:0]    rq_btype;
  logic [1:0]    rs_valid, rs_ready;
  logic [2*NB-1:0] rs_c;
  logic [1:0]    rs_ovf, rs_bcond;
  logic [NB-1:0] alu_a, alu_b, alu_c;
  logic [3:0]    alu_func;
  logic [1:0]    alu_btype;
  logic          alu_ovf, alu_bcond;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_full [2];
  logic [NB-1:0] m_c    [2];
  bit            m_ovf  [2];
  bit            m_bc   [2];
  int            m_ptr;
  int            m_gnt;
  bit            pend   [2];

  alu_share_arbiter #(.NUM_BITS(NB), .RESET_PRIO(RP)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_a(rq_a), .rq_b(rq_b),
    .rq_func(rq_func), .rq_btype(rq_btype),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_c(rs_c),
    .rs_ovf(rs_ovf), .rs_bcond(rs_bcond),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_btype(alu_btype),
    .alu_c(alu_c), .alu_ovf(alu_ovf), .alu_bcond(alu_bcond)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {ovf, bcond, c}; bcond is computed for every op
  function automatic logic [NB+1:0] alu_ref(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic [3:0] f, input logic [1:0] t);
    logic [NB-1:0] c;
    logic          o, bc;
    o = 1'b0;
    case (f)
      FUNC_ADD: begin
        c = a + b;
        o = (a[NB-1] == b[NB-1]) && (c[NB-1] != a[NB-1]);
      end
      FUNC_SUB, FUNC_BXX: begin
        c = a - b;
        o = (a[NB-1] != b[NB-1]) && (c[NB-1] != a[NB-1]);
      end
      FUNC_AND: c = a & b;
      FUNC_ORR: c = a | b;
      FUNC_NOT: c = ~a;
      FUNC_ID1: c = a;
      default:  c = a ^ b;
    endcase
    case (t)
      BNE:     bc = (a != b);
      BEQ:     bc = (a == b);
      BGZ:     bc = ($signed(a) > 0);
      default: bc = ($signed(a) < 0);
    endcase
    return {o, bc, c};
  endfunction

  assign {alu_ovf, alu_bcond, alu_c} = alu_ref(alu_a, alu_b, alu_func, alu_btype);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_rq(input int i, input logic v, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [3:0] f, input logic [1:0] t);
    rq_valid[i]       = v;
    rq_a[i*NB +: NB]  = a;
    rq_b[i*NB +: NB]  = b;
    rq_func[i*4 +: 4] = f;
    rq_btype[i*2 +: 2] = t;
  endtask

  // One clock: check grant/ALU drive, then the registered responses after the edge.
  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic [1:0]    elig, exp_rdy;
    logic [NB-1:0] ea, eb;
    logic [3:0]    ef;
    logic [1:0]    et;
    logic [NB+1:0] r;
    #1;
    for (int i = 0; i < 2; i++) elig[i] = !reset && rq_valid[i] && (!m_full[i] || rs_ready[i]);
    if (elig == 2'b11)  m_gnt = m_ptr;
    else if (elig[0])   m_gnt = 0;
    else if (elig[1])   m_gnt = 1;
    else                m_gnt = -1;
    if (m_gnt < 0) begin
      exp_rdy = 2'b00; ea = '0; eb = '0; ef = FUNC_ID1; et = 2'b00;
    end else begin
      exp_rdy = (m_gnt == 0) ? 2'b01 : 2'b10;
      ea = rq_a[m_gnt*NB +: NB];
      eb = rq_b[m_gnt*NB +: NB];
      ef = rq_func[m_gnt*4 +: 4];
      et = rq_btype[m_gnt*2 +: 2];
    end
    check("rq_ready", 32'(rq_ready), 32'(exp_rdy));
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(eb));
    check("alu_func", 32'(alu_func), 32'(ef));
    check("alu_btype", 32'(alu_btype), 32'(et));
    r = alu_ref(ea, eb, ef, et);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 0; m_c[i] = '0; m_ovf[i] = 0; m_bc[i] = 0;
      end
      m_ptr = RP;
    end else begin
      for (int i = 0; i < 2; i++) if (m_full[i] && rs_ready[i]) m_full[i] = 0;
      if (m_gnt >= 0) begin
        m_full[m_gnt] = 1;
        m_c[m_gnt]    = r[NB-1:0];
        m_ovf[m_gnt]  = r[NB+1];
        m_bc[m_gnt]   = (ef == FUNC_BXX) ? r[NB] : 1'b0;
        m_ptr         = 1 - m_gnt;
      end
    end
    check("rs_valid", 32'(rs_valid), 32'({m_full[1], m_full[0]}));
    check("rs_c", rs_c, {m_c[1], m_c[0]});
    check("rs_ovf", 32'(rs_ovf), 32'({m_ovf[1], m_ovf[0]}));
    check("rs_bcond", 32'(rs_bcond), 32'({m_bc[1], m_bc[0]}));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rq_valid = '0; rq_a = '0; rq_b = '0; rq_func = '0; rq_btype = '0; rs_ready = '0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_c[i] = '0; m_ovf[i] = 0; m_bc[i] = 0; pend[i] = 0;
    end
    m_ptr = RP; m_gnt = -1;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;

    // r1 ADD 3+4, result visible the next cycle
    set_rq(1, 1, 16'h0003, 16'h0004, FUNC_ADD, BNE);
    rs_ready = 2'b10;
    cycle();
    check("add_c", 32'(rs_c[31:16]), 32'h0007);
    check("add_valid", 32'(rs_valid[1]), 32'd1);
    check("add_ovf", 32'(rs_ovf[1]), 32'd0);
    rq_valid = 2'b00;

    // both request continuously: grants alternate
    set_rq(0, 1, 16'h0010, 16'h0001, FUNC_SUB, BEQ);
    set_rq(1, 1, 16'h00F0, 16'h0F00, FUNC_ORR, BNE);
    rs_ready = 2'b11;
    repeat (4) cycle();
    rq_valid = 2'b00;
    cycle();

    // r0 overflow result held while not consumed; new r0 request waits
    set_rq(0, 1, 16'h7FFF, 16'h0001, FUNC_ADD, BNE);
    rs_ready = 2'b00;
    cycle();
    set_rq(0, 1, 16'h1234, 16'h0034, FUNC_SUB, BNE);
    repeat (3) cycle();
    check("ovf_hold_c", 32'(rs_c[15:0]), 32'h8000);
    check("ovf_hold_f", 32'(rs_ovf[0]), 32'd1);
    rs_ready = 2'b01;
    cycle();
    check("reload_c", 32'(rs_c[15:0]), 32'h1200);
    rq_valid = 2'b00;
    cycle();

    // branch bcond reported, then masked on a following SUB
    rs_ready = 2'b10;
    set_rq(1, 1, 16'h0005, 16'h0000, FUNC_BXX, BGZ);
    cycle();
    check("bxx_bcond", 32'(rs_bcond[1]), 32'd1);
    set_rq(1, 1, 16'h0005, 16'h0005, FUNC_SUB, BGZ);
    cycle();
    check("sub_c", 32'(rs_c[31:16]), 32'h0000);
    check("sub_bcond", 32'(rs_bcond[1]), 32'd0);

    // only r1, then both: r0 wins the tie
    rq_valid = 2'b10;
    rs_ready = 2'b11;
    cycle();
    rq_valid = 2'b11;
    cycle();
    cycle();

    // fill both slots, then reset with requests pending
    rs_ready = 2'b00;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_drop", 32'(rs_valid), 32'd0);
    rs_ready = 2'b11;
    cycle();

    // randomized traffic with requesters holding requests until granted
    rq_valid = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i] = 1;
          set_rq(i, 1, NB'($urandom), NB'($urandom % 4 == 0 ? 32'd0 : $urandom),
                 ($urandom % 4 == 0) ? FUNC_BXX : 4'($urandom), 2'($urandom));
        end
        rq_valid[i] = pend[i];
      end
      rs_ready = 2'($urandom);
      reset    = ($urandom % 64 == 0);
      cycle();
      for (int i = 0; i < 2; i++) if (m_gnt == i) pend[i] = 0;
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
